id_stage: RTL and testbench

- Decode stage of the 5-stage RV32I pipeline.
- Sits between the fetch stage's IF/ID register and the execute stage.
- Contains:
  - the 32x32 register file, written from writeback;
  - the main decoder and immediate generator;
  - load-use hazard detection, which drives the fetch-side stall enables;
  - the ID/EX pipeline register, which supports flush and bubble insertion.

---
 rtl/riscv_pkg.sv | 78 +++++++
 rtl/id_stage_if.sv | 36 +++
 rtl/id_stage_reg_file.sv | 42 ++++
 rtl/id_stage.sv | 184 ++++++++++++++++++
 tb/tb_id_stage.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU/result/immediate encodings,
// and the ID/EX control bundle used by id_stage.
package riscv_pkg;

  localparam int RV_XLEN  = 32;
  localparam int RV_NREGS = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BUBBLE = 7'b0000000;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        jump_reg;
    logic        alu_src_b;
    logic        alu_src_a_pc;
    result_src_e result_src;
    alu_ctrl_e   alu_ctrl;
    logic        illegal;
  } ctrl_t;

  // Shared by OP and OP-IMM; allow_sub is 0 for OP-IMM, where bit 30 is immediate data.
  function automatic alu_ctrl_e alu_from_funct3(input logic [2:0] funct3,
                                                input logic funct7_5,
                                                input logic allow_sub);
    case (funct3)
      3'b000:  return (allow_sub && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// IF/ID field inputs and ID/EX register outputs of the decode stage.
// master = decode stage, slave = surrounding pipeline (fetch/execute).
interface id_stage_if #(parameter int XLEN = 32);

  logic [4:0]      rs1_i, rs2_i, rd_i;
  logic [24:0]     Instr31_7_i;
  logic [6:0]      op_i;
  logic [2:0]      funct3_i;
  logic            funct7_5_i;
  logic [XLEN-1:0] PC_i, pcPlus4_i;

  logic [XLEN-1:0] rd1_o, rd2_o, imm_o;
  logic [4:0]      rs1_o, rs2_o, rd_o;
  logic [XLEN-1:0] PC_o, pcPlus4_o;
  logic [2:0]      funct3_o;
  logic            regWrite_o, memRead_o, memWrite_o, branch_o;
  logic            jump_o, jumpReg_o, aluSrcB_o, aluSrcAPC_o;
  logic [1:0]      resultSrc_o;
  logic [3:0]      aluCtrl_o;
  logic            illegal_o;

  modport master (
    input  rs1_i, rs2_i, rd_i, Instr31_7_i, op_i, funct3_i, funct7_5_i, PC_i, pcPlus4_i,
    output rd1_o, rd2_o, imm_o, rs1_o, rs2_o, rd_o, PC_o, pcPlus4_o, funct3_o,
           regWrite_o, memRead_o, memWrite_o, branch_o, jump_o, jumpReg_o,
           aluSrcB_o, aluSrcAPC_o, resultSrc_o, aluCtrl_o, illegal_o
  );

  modport slave (
    output rs1_i, rs2_i, rd_i, Instr31_7_i, op_i, funct3_i, funct7_5_i, PC_i, pcPlus4_i,
    input  rd1_o, rd2_o, imm_o, rs1_o, rs2_o, rd_o, PC_o, pcPlus4_o, funct3_o,
           regWrite_o, memRead_o, memWrite_o, branch_o, jump_o, jumpReg_o,
           aluSrcB_o, aluSrcAPC_o, resultSrc_o, aluCtrl_o, illegal_o
  );

endinterface

// File: rtl/id_stage_reg_file.sv
// 2-read/1-write register file, x0 hard-wired to zero, synchronous active-low reset.
// Optional macro RF_WB_BYPASS_EN: same-cycle write data is visible on the read ports.
module reg_file #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] regs [NREGS];

  // NOTE: the array is reset in full because the reset contract clears every
  // architectural register; this forces flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] ra);
    if (ra == '0) return '0;
`ifdef RF_WB_BYPASS_EN
    if (we && wa == ra) return wd;
`endif
    return regs[ra];
  endfunction

  assign rd1 = read_port(ra1);
  assign rd2 = read_port(ra2);

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: register file, decoder, immediate generator, load-use
// hazard detection and the ID/EX register. Optional macro: RF_WB_BYPASS_EN (reg_file).
module id_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = RV_XLEN,
  parameter int NREGS = RV_NREGS
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            wbEn_i,
  input  logic [4:0]      wbRd_i,
  input  logic [XLEN-1:0] wbData_i,
  output logic            PCEn_o,
  output logic            IF_ID_En_o,
  id_stage_if.master      bus
);

  logic [XLEN-1:0] rf_rd1, rf_rd2;
  logic [31:0]     instr;
  ctrl_t           ctrl;
  imm_type_e       imm_type;
  logic [XLEN-1:0] imm;
  logic            load_use;

  ctrl_t           ctrl_q;
  logic [XLEN-1:0] rd1_q, rd2_q, imm_q, pc_q, pc_plus4_q;
  logic [4:0]      rs1_q, rs2_q, rd_q;
  logic [2:0]      funct3_q;

  reg_file #(.XLEN(XLEN), .NREGS(NREGS)) u_reg_file (
    .clk   (clk_i),
    .rst_n (rst_i),
    .we    (wbEn_i),
    .wa    (wbRd_i),
    .wd    (wbData_i),
    .ra1   (bus.rs1_i),
    .ra2   (bus.rs2_i),
    .rd1   (rf_rd1),
    .rd2   (rf_rd2)
  );

  assign instr = {bus.Instr31_7_i, bus.op_i};

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    ctrl     = '0;
    imm_type = IMM_NONE;
    case (bus.op_i)
      OPC_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.alu_ctrl  = ALU_PASSB;
        imm_type       = IMM_U;
      end
      OPC_AUIPC: begin
        ctrl.reg_write    = 1'b1;
        ctrl.alu_src_b    = 1'b1;
        ctrl.alu_src_a_pc = 1'b1;
        imm_type          = IMM_U;
      end
      OPC_JAL: begin
        ctrl.reg_write    = 1'b1;
        ctrl.jump         = 1'b1;
        ctrl.alu_src_b    = 1'b1;
        ctrl.alu_src_a_pc = 1'b1;
        ctrl.result_src   = RES_PC4;
        imm_type          = IMM_J;
      end
      OPC_JALR: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.jump_reg   = 1'b1;
        ctrl.alu_src_b  = 1'b1;
        ctrl.result_src = RES_PC4;
        imm_type        = IMM_I;
      end
      OPC_BRANCH: begin
        ctrl.branch = 1'b1;
        // Comparison flavour only; the branch condition itself is resolved in EX.
        case (bus.funct3_i[2:1])
          2'b10:   ctrl.alu_ctrl = ALU_SLT;
          2'b11:   ctrl.alu_ctrl = ALU_SLTU;
          default: ctrl.alu_ctrl = ALU_SUB;
        endcase
        imm_type = IMM_B;
      end
      OPC_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.alu_src_b  = 1'b1;
        ctrl.result_src = RES_MEM;
        imm_type        = IMM_I;
      end
      OPC_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        imm_type       = IMM_S;
      end
      OPC_OP_IMM: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.alu_ctrl  = alu_from_funct3(bus.funct3_i, bus.funct7_5_i, 1'b0);
        imm_type       = IMM_I;
      end
      OPC_OP: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_ctrl  = alu_from_funct3(bus.funct3_i, bus.funct7_5_i, 1'b1);
      end
      OPC_BUBBLE: ;
      default: ctrl.illegal = 1'b1;
    endcase
  end

  always_comb begin
    imm = '0;
    case (imm_type)
      IMM_I:   imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
      IMM_J:   imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  // Gated by rst_i so the front end is never frozen while the pipeline is in reset.
  assign load_use = rst_i && ctrl_q.mem_read && (rd_q != '0) &&
                    ((rd_q == bus.rs1_i) || (rd_q == bus.rs2_i)) && !flush_i;

  assign PCEn_o     = !load_use;
  assign IF_ID_En_o = !load_use;

  // Reset, flush and the load-use bubble all load an all-zero ID/EX word.
  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_i || flush_i || load_use) begin
      ctrl_q     <= '0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      funct3_q   <= '0;
    end else begin
      ctrl_q     <= ctrl;
      rd1_q      <= rf_rd1;
      rd2_q      <= rf_rd2;
      imm_q      <= imm;
      rs1_q      <= bus.rs1_i;
      rs2_q      <= bus.rs2_i;
      rd_q       <= bus.rd_i;
      pc_q       <= bus.PC_i;
      pc_plus4_q <= bus.pcPlus4_i;
      funct3_q   <= bus.funct3_i;
    end
  end

  assign bus.rd1_o       = rd1_q;
  assign bus.rd2_o       = rd2_q;
  assign bus.imm_o       = imm_q;
  assign bus.rs1_o       = rs1_q;
  assign bus.rs2_o       = rs2_q;
  assign bus.rd_o        = rd_q;
  assign bus.PC_o        = pc_q;
  assign bus.pcPlus4_o   = pc_plus4_q;
  assign bus.funct3_o    = funct3_q;
  assign bus.regWrite_o  = ctrl_q.reg_write;
  assign bus.memRead_o   = ctrl_q.mem_read;
  assign bus.memWrite_o  = ctrl_q.mem_write;
  assign bus.branch_o    = ctrl_q.branch;
  assign bus.jump_o      = ctrl_q.jump;
  assign bus.jumpReg_o   = ctrl_q.jump_reg;
  assign bus.aluSrcB_o   = ctrl_q.alu_src_b;
  assign bus.aluSrcAPC_o = ctrl_q.alu_src_a_pc;
  assign bus.resultSrc_o = ctrl_q.result_src;
  assign bus.aluCtrl_o   = ctrl_q.alu_ctrl;
  assign bus.illegal_o   = ctrl_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage: reset, register file, decode,
// immediates, load-use stall, flush priority and same-cycle write/read.
module tb_id_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        pc_en, if_id_en;

  int n_cmp = 0;
  int n_err = 0;

  id_stage_if #(.XLEN(32)) bus ();

  id_stage dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .flush_i    (flush),
    .wbEn_i     (wb_en),
    .wbRd_i     (wb_rd),
    .wbData_i   (wb_data),
    .PCEn_o     (pc_en),
    .IF_ID_En_o (if_id_en),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Hand-encoded instructions
  localparam logic [31:0] I_ADD_X6_X5_X0 = 32'h0002_8333;
  localparam logic [31:0] I_ADD_X6_X0_X0 = 32'h0000_0333;
  localparam logic [31:0] I_ADD_X6_X3_X0 = 32'h0001_8333;
  localparam logic [31:0] I_LW_X7        = 32'h0000_A383;  // lw  x7, 0(x1)
  localparam logic [31:0] I_ADD_X8_X1_X7 = 32'h0070_8433;
  localparam logic [31:0] I_BEQ_M8       = 32'hFE00_0CE3;  // beq x0, x0, -8
  localparam logic [31:0] I_SW_7FC       = 32'h7E20_2E23;  // sw  x2, 0x7fc(x0)
  localparam logic [31:0] I_LUI_ABCDE    = 32'hABCD_E0B7;  // lui x1, 0xabcde
  localparam logic [31:0] I_SUB          = 32'h4031_00B3;  // sub x1, x2, x3
  localparam logic [31:0] I_ADDI_400     = 32'h4001_0093;  // addi x1, x2, 0x400
  localparam logic [31:0] I_SRAI_3       = 32'h4031_5093;  // srai x1, x2, 3
  localparam logic [31:0] I_ILLEGAL      = 32'h0000_007F;

  task automatic drive(input logic [31:0] ins);
    bus.Instr31_7_i = ins[31:7];
    bus.op_i        = ins[6:0];
    bus.rd_i        = ins[11:7];
    bus.funct3_i    = ins[14:12];
    bus.rs1_i       = ins[19:15];
    bus.rs2_i       = ins[24:20];
    bus.funct7_5_i  = ins[30];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ctrl_bits();
    return {bus.regWrite_o, bus.memRead_o, bus.memWrite_o, bus.branch_o,
            bus.jump_o, bus.jumpReg_o, bus.aluSrcB_o, bus.aluSrcAPC_o};
  endfunction

  function automatic logic [255:0] idex_bits();
    return {63'b0, bus.rd1_o, bus.rd2_o, bus.imm_o, bus.rs1_o, bus.rs2_o, bus.rd_o,
            bus.PC_o, bus.pcPlus4_o, bus.funct3_o, ctrl_bits(), bus.resultSrc_o,
            bus.aluCtrl_o, bus.illegal_o};
  endfunction

  task automatic test_reset();
    drive(I_ADD_X6_X5_X0);
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (idex_bits() !== 256'b0) begin
      n_err++; $display("FAIL reset_idex: got %h expected 0", idex_bits());
    end
    n_cmp++;
    if ({pc_en, if_id_en} !== 2'b11) begin
      n_err++; $display("FAIL reset_enables: got %b expected 11", {pc_en, if_id_en});
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (bus.rd1_o !== 32'h0) begin
      n_err++; $display("FAIL reset_x5_read: got %h expected 00000000", bus.rd1_o);
    end
  endtask

  task automatic test_regfile();
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    drive(32'h0);
    tick();
    wb_en = 1'b0;
    drive(I_ADD_X6_X5_X0);
    bus.PC_i = 32'h100; bus.pcPlus4_i = 32'h104;
    tick();
    n_cmp++;
    if (bus.rd1_o !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL add_rd1: got %h expected deadbeef", bus.rd1_o);
    end
    n_cmp++;
    if ({ctrl_bits(), bus.aluCtrl_o, bus.resultSrc_o, bus.rd_o} !== {8'b1000_0000, 4'(ALU_ADD), 2'b00, 5'd6}) begin
      n_err++; $display("FAIL add_ctrl: got ctrl=%b alu=%0d res=%b rd=%0d expected ctrl=10000000 alu=0 res=00 rd=6",
                        ctrl_bits(), bus.aluCtrl_o, bus.resultSrc_o, bus.rd_o);
    end
    n_cmp++;
    if ({bus.PC_o, bus.pcPlus4_o} !== {32'h100, 32'h104}) begin
      n_err++; $display("FAIL add_pc: got %h/%h expected 00000100/00000104", bus.PC_o, bus.pcPlus4_o);
    end
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234;
    drive(32'h0);
    tick();
    wb_en = 1'b0;
    drive(I_ADD_X6_X0_X0);
    tick();
    n_cmp++;
    if (bus.rd1_o !== 32'h0) begin
      n_err++; $display("FAIL x0_write_ignored: got %h expected 00000000", bus.rd1_o);
    end
  endtask

  task automatic test_load_use();
    drive(I_LW_X7);
    tick();
    n_cmp++;
    if ({ctrl_bits(), bus.resultSrc_o, bus.rd_o} !== {8'b1100_0010, 2'b01, 5'd7}) begin
      n_err++; $display("FAIL lw_ctrl: got ctrl=%b res=%b rd=%0d expected ctrl=11000010 res=01 rd=7",
                        ctrl_bits(), bus.resultSrc_o, bus.rd_o);
    end
    drive(I_ADD_X8_X1_X7);
    #1;
    n_cmp++;
    if ({pc_en, if_id_en} !== 2'b00) begin
      n_err++; $display("FAIL load_use_stall: got %b expected 00", {pc_en, if_id_en});
    end
    tick();
    n_cmp++;
    if (idex_bits() !== 256'b0) begin
      n_err++; $display("FAIL load_use_bubble: got %h expected 0", idex_bits());
    end
    n_cmp++;
    if ({pc_en, if_id_en} !== 2'b11) begin
      n_err++; $display("FAIL stall_one_cycle: got %b expected 11", {pc_en, if_id_en});
    end
    tick();
    n_cmp++;
    if ({ctrl_bits(), bus.rd_o, bus.rs2_o} !== {8'b1000_0000, 5'd8, 5'd7}) begin
      n_err++; $display("FAIL after_bubble: got ctrl=%b rd=%0d rs2=%0d expected ctrl=10000000 rd=8 rs2=7",
                        ctrl_bits(), bus.rd_o, bus.rs2_o);
    end
  endtask

  task automatic test_flush_priority();
    drive(I_LW_X7);
    tick();
    drive(I_ADD_X8_X1_X7);
    flush = 1'b1;
    #1;
    n_cmp++;
    if ({pc_en, if_id_en} !== 2'b11) begin
      n_err++; $display("FAIL flush_no_stall: got %b expected 11", {pc_en, if_id_en});
    end
    tick();
    flush = 1'b0;
    n_cmp++;
    if (idex_bits() !== 256'b0) begin
      n_err++; $display("FAIL flush_clears: got %h expected 0", idex_bits());
    end
  endtask

  task automatic test_immediates();
    drive(I_BEQ_M8);
    tick();
    n_cmp++;
    if ({bus.imm_o, ctrl_bits(), bus.aluCtrl_o} !== {32'hFFFFFFF8, 8'b0001_0000, 4'(ALU_SUB)}) begin
      n_err++; $display("FAIL beq_imm: got imm=%h ctrl=%b alu=%0d expected fffffff8/00010000/1",
                        bus.imm_o, ctrl_bits(), bus.aluCtrl_o);
    end
    drive(I_SW_7FC);
    tick();
    n_cmp++;
    if ({bus.imm_o, ctrl_bits()} !== {32'h000007FC, 8'b0010_0010}) begin
      n_err++; $display("FAIL sw_imm: got imm=%h ctrl=%b expected 000007fc/00100010", bus.imm_o, ctrl_bits());
    end
    drive(I_LUI_ABCDE);
    tick();
    n_cmp++;
    if ({bus.imm_o, ctrl_bits(), bus.aluCtrl_o} !== {32'hABCDE000, 8'b1000_0010, 4'(ALU_PASSB)}) begin
      n_err++; $display("FAIL lui_imm: got imm=%h ctrl=%b alu=%0d expected abcde000/10000010/10",
                        bus.imm_o, ctrl_bits(), bus.aluCtrl_o);
    end
  endtask

  task automatic test_alu_select();
    drive(I_SUB);
    tick();
    n_cmp++;
    if (bus.aluCtrl_o !== 4'(ALU_SUB)) begin
      n_err++; $display("FAIL op_sub: got %0d expected 1", bus.aluCtrl_o);
    end
    drive(I_ADDI_400);
    tick();
    n_cmp++;
    if ({bus.aluCtrl_o, bus.imm_o} !== {4'(ALU_ADD), 32'h00000400}) begin
      n_err++; $display("FAIL addi_no_sub: got alu=%0d imm=%h expected 0/00000400", bus.aluCtrl_o, bus.imm_o);
    end
    drive(I_SRAI_3);
    tick();
    n_cmp++;
    if ({bus.aluCtrl_o, bus.imm_o} !== {4'(ALU_SRA), 32'h00000403}) begin
      n_err++; $display("FAIL srai: got alu=%0d imm=%h expected 7/00000403", bus.aluCtrl_o, bus.imm_o);
    end
  endtask

  task automatic test_illegal();
    drive(I_ILLEGAL);
    tick();
    n_cmp++;
    if ({ctrl_bits(), bus.resultSrc_o, bus.aluCtrl_o, bus.illegal_o} !== {8'b0, 2'b00, 4'd0, 1'b1}) begin
      n_err++; $display("FAIL illegal_op: got ctrl=%b res=%b alu=%0d ill=%b expected 0/0/0/1",
                        ctrl_bits(), bus.resultSrc_o, bus.aluCtrl_o, bus.illegal_o);
    end
    drive(32'h0);
    tick();
    n_cmp++;
    if ({ctrl_bits(), bus.illegal_o} !== 9'b0) begin
      n_err++; $display("FAIL bubble_opcode: got ctrl=%b ill=%b expected 0/0", ctrl_bits(), bus.illegal_o);
    end
  endtask

  task automatic test_same_cycle_wb();
    logic [31:0] exp_first;
`ifdef RF_WB_BYPASS_EN
    exp_first = 32'h55;
`else
    exp_first = 32'h11;
`endif
    wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'h11;
    drive(32'h0);
    tick();
    wb_data = 32'h55;
    drive(I_ADD_X6_X3_X0);
    tick();
    n_cmp++;
    if (bus.rd1_o !== exp_first) begin
      n_err++; $display("FAIL same_cycle_read: got %h expected %h", bus.rd1_o, exp_first);
    end
    wb_en = 1'b0;
    tick();
    n_cmp++;
    if (bus.rd1_o !== 32'h55) begin
      n_err++; $display("FAIL next_cycle_read: got %h expected 00000055", bus.rd1_o);
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(I_LW_X7);
    tick();
    drive(I_ADD_X8_X1_X7);
    #1;
    n_cmp++;
    if (pc_en !== 1'b0) begin
      n_err++; $display("FAIL pre_reset_stall: got %b expected 0", pc_en);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({pc_en, if_id_en} !== 2'b11) begin
      n_err++; $display("FAIL reset_drops_stall: got %b expected 11", {pc_en, if_id_en});
    end
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if (idex_bits() !== 256'b0) begin
      n_err++; $display("FAIL reset_mid_stall_idex: got %h expected 0", idex_bits());
    end
    drive(I_ADD_X6_X5_X0);
    tick();
    n_cmp++;
    if (bus.rd1_o !== 32'h0) begin
      n_err++; $display("FAIL rf_cleared: got %h expected 00000000", bus.rd1_o);
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    bus.PC_i = '0; bus.pcPlus4_i = '0;
    drive(32'h0);
    #2;
    test_reset();
    test_regfile();
    test_load_use();
    test_flush_priority();
    test_immediates();
    test_alu_select();
    test_illegal();
    test_same_cycle_wb();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
